ov7670_captura_grade: RTL and testbench

- Parametrised successor of the OV7670 capture interface: captures one RGB565 frame on request and accumulates per-cell colour averages over a GRID x GRID window grid, e.g. the 3x3 stickers of a cube face.
- Sits between the camera pins and the colour-classification logic.
- Generalises frame size, grid size, window placement and size, and byte order.
- Adds frame-length checking, XCLK generation and a random-access cell readout.

---
 rtl/ov7670_captura_grade.sv | 226 ++++++++++++++++++++++
 tb/tb_ov7670_captura_grade.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_captura_grade.sv
// OV7670 RGB565 frame capture with per-cell colour averaging over a GRID x GRID window grid.
// Camera pins are treated as data: synchronised into the clock domain and edge-detected there.
module ov7670_captura_grade #(
    parameter int LINES     = 176,
    parameter int COLUMNS   = 288,
    parameter int GRID      = 3,
    parameter int X0        = 48,
    parameter int Y0        = 16,
    parameter int PITCH_X   = 80,
    parameter int PITCH_Y   = 56,
    parameter int LOG_CW    = 4,
    parameter int LOG_CH    = 4,
    parameter bit BYTE_SWAP = 1'b0,
    localparam int NCELL    = GRID * GRID,
    localparam int SEL_W    = (NCELL > 1) ? $clog2(NCELL) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iniciar,
    input  logic             VSYNC,
    input  logic             HREF,
    input  logic             PCLK,
    input  logic [7:0]       D,
    input  logic [SEL_W-1:0] cell_sel,
    output logic             XCLK,
    output logic             PWDN,
    output logic             ocupado,
    output logic             pronto,
    output logic             erro_frame,
    output logic [15:0]      pixel,
    output logic             pixel_valido,
    output logic [4:0]       cell_r,
    output logic [5:0]       cell_g,
    output logic [4:0]       cell_b,
    output logic [3:0]       db_estado
);

    localparam int SH   = LOG_CW + LOG_CH;
    localparam int AR_W = 5 + SH;
    localparam int AG_W = 6 + SH;

    typedef enum logic [3:0] {
        OCIOSO        = 4'd0,
        ESPERA_ALTO   = 4'd1,
        ESPERA_INICIO = 4'd2,
        CAPTURA       = 4'd3,
        PRONTO        = 4'd4
    } estado_t;

    estado_t estado;

    logic [1:0]  vsync_s, href_s, pclk_s;
    logic [7:0]  d_m, d_s;
    logic        vsync_d, href_d, pclk_d, iniciar_d;
    logic        vsync_rise, vsync_fall, href_fall, pclk_rise, ini_rise;

    logic        byte_tog, sticky;
    logic [7:0]  byte0;
    logic [15:0] col_cnt, line_cnt, px_col, px_line;
    logic        clr_acc;
    logic [NCELL-1:0] hit;

    logic [AR_W-1:0] acc_r [NCELL];
    logic [AG_W-1:0] acc_g [NCELL];
    logic [AR_W-1:0] acc_b [NCELL];

    assign PWDN      = 1'b0;
    assign db_estado = estado;

    // Edges are taken between the second sync stage and its delayed copy, so D from d_s lines up with pclk_rise.
    assign vsync_rise = vsync_s[1] & ~vsync_d;
    assign vsync_fall = ~vsync_s[1] & vsync_d;
    assign href_fall  = ~href_s[1] & href_d;
    assign pclk_rise  = pclk_s[1] & ~pclk_d;
    assign ini_rise   = iniciar & ~iniciar_d;
    assign clr_acc    = (estado == ESPERA_INICIO) && vsync_fall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vsync_s   <= '0;
            href_s    <= '0;
            pclk_s    <= '0;
            d_m       <= '0;
            d_s       <= '0;
            vsync_d   <= 1'b0;
            href_d    <= 1'b0;
            pclk_d    <= 1'b0;
            iniciar_d <= 1'b0;
            XCLK      <= 1'b0;
        end else begin
            vsync_s   <= {vsync_s[0], VSYNC};
            href_s    <= {href_s[0], HREF};
            pclk_s    <= {pclk_s[0], PCLK};
            d_m       <= D;
            d_s       <= d_m;
            vsync_d   <= vsync_s[1];
            href_d    <= href_s[1];
            pclk_d    <= pclk_s[1];
            iniciar_d <= iniciar;
            XCLK      <= ~XCLK;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= OCIOSO;
            ocupado      <= 1'b0;
            pronto       <= 1'b0;
            erro_frame   <= 1'b0;
            pixel        <= '0;
            pixel_valido <= 1'b0;
            byte_tog     <= 1'b0;
            byte0        <= '0;
            sticky       <= 1'b0;
            col_cnt      <= '0;
            line_cnt     <= '0;
            px_col       <= '0;
            px_line      <= '0;
        end else begin
            pixel_valido <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (ini_rise) estado <= ESPERA_ALTO;
                end
                ESPERA_ALTO: begin
                    // Waiting for blanking first means a request landing mid-frame skips to the next whole frame.
                    if (vsync_s[1]) estado <= ESPERA_INICIO;
                end
                ESPERA_INICIO: begin
                    if (vsync_fall) begin
                        estado   <= CAPTURA;
                        ocupado  <= 1'b1;
                        col_cnt  <= '0;
                        line_cnt <= '0;
                        sticky   <= 1'b0;
                        byte_tog <= 1'b0;
                    end
                end
                CAPTURA: begin
                    if (vsync_rise) begin
                        estado     <= PRONTO;
                        ocupado    <= 1'b0;
                        pronto     <= 1'b1;
                        erro_frame <= sticky | (line_cnt != 16'(LINES));
                    end else if (pclk_rise && href_s[1]) begin
                        if (!byte_tog) begin
                            byte0    <= d_s;
                            byte_tog <= 1'b1;
                        end else begin
                            byte_tog     <= 1'b0;
                            pixel        <= BYTE_SWAP ? {d_s, byte0} : {byte0, d_s};
                            pixel_valido <= 1'b1;
                            px_col       <= col_cnt;
                            px_line      <= line_cnt;
                            col_cnt      <= col_cnt + 16'd1;
                        end
                    end else if (href_fall) begin
                        // Clearing the toggle here drops any odd trailing byte of the line.
                        byte_tog <= 1'b0;
                        if (col_cnt != '0) begin
                            if (col_cnt != 16'(COLUMNS)) sticky <= 1'b1;
                            line_cnt <= line_cnt + 16'd1;
                            col_cnt  <= '0;
                        end
                    end
                end
                PRONTO: begin
                    if (ini_rise) begin
                        estado <= ESPERA_ALTO;
                        pronto <= 1'b0;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    always_comb begin
        hit = '0;
        for (int r = 0; r < GRID; r++) begin
            for (int c = 0; c < GRID; c++) begin
                hit[r*GRID+c] = (px_line >= 16'(Y0 + r*PITCH_Y)) &&
                                (px_line <  16'(Y0 + r*PITCH_Y + (1 << LOG_CH))) &&
                                (px_col  >= 16'(X0 + c*PITCH_X)) &&
                                (px_col  <  16'(X0 + c*PITCH_X + (1 << LOG_CW)));
            end
        end
    end

    // Accumulators are sized for a full window of saturated pixels, so they cannot wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCELL; i++) begin
                acc_r[i] <= '0;
                acc_g[i] <= '0;
                acc_b[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCELL; i++) begin
                if (clr_acc) begin
                    acc_r[i] <= '0;
                    acc_g[i] <= '0;
                    acc_b[i] <= '0;
                end else if (pixel_valido && hit[i]) begin
                    acc_r[i] <= acc_r[i] + AR_W'(pixel[15:11]);
                    acc_g[i] <= acc_g[i] + AG_W'(pixel[10:5]);
                    acc_b[i] <= acc_b[i] + AR_W'(pixel[4:0]);
                end
            end
        end
    end

    always_comb begin
        cell_r = '0;
        cell_g = '0;
        cell_b = '0;
        for (int i = 0; i < NCELL; i++) begin
            if (cell_sel == SEL_W'(i)) begin
                cell_r = acc_r[i][SH +: 5];
                cell_g = acc_g[i][SH +: 6];
                cell_b = acc_b[i][SH +: 5];
            end
        end
    end

endmodule

// File: tb/tb_ov7670_captura_grade.sv
// Directed bench for ov7670_captura_grade on an 8x8 frame with a 2x2 grid of 4x4 cells.
module tb_ov7670_captura_grade;

    localparam int LINES = 8;
    localparam int COLS  = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        iniciar = 1'b0;
    logic        VSYNC = 1'b1;
    logic        HREF = 1'b0;
    logic        PCLK = 1'b0;
    logic [7:0]  D = 8'h00;
    logic [1:0]  cell_sel = 2'd0;

    logic        XCLK, PWDN, ocupado, pronto, erro_frame, pixel_valido;
    logic [15:0] pixel;
    logic [4:0]  cell_r, cell_b;
    logic [5:0]  cell_g;
    logic [3:0]  db_estado;

    logic        s_XCLK, s_PWDN, s_ocupado, s_pronto, s_erro_frame, s_pixel_valido;
    logic [15:0] s_pixel;
    logic [4:0]  s_cell_r, s_cell_b;
    logic [5:0]  s_cell_g;
    logic [3:0]  s_db_estado;

    int n_cmp = 0;
    int n_bad = 0;
    int pv_count = 0;

    ov7670_captura_grade #(
        .LINES(LINES), .COLUMNS(COLS), .GRID(2), .X0(0), .Y0(0), .PITCH_X(4), .PITCH_Y(4),
        .LOG_CW(2), .LOG_CH(2), .BYTE_SWAP(1'b0)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .VSYNC(VSYNC), .HREF(HREF),
        .PCLK(PCLK), .D(D), .cell_sel(cell_sel), .XCLK(XCLK), .PWDN(PWDN),
        .ocupado(ocupado), .pronto(pronto), .erro_frame(erro_frame), .pixel(pixel),
        .pixel_valido(pixel_valido), .cell_r(cell_r), .cell_g(cell_g), .cell_b(cell_b),
        .db_estado(db_estado)
    );

    ov7670_captura_grade #(
        .LINES(LINES), .COLUMNS(COLS), .GRID(2), .X0(0), .Y0(0), .PITCH_X(4), .PITCH_Y(4),
        .LOG_CW(2), .LOG_CH(2), .BYTE_SWAP(1'b1)
    ) dut_swap (
        .clock(clock), .reset(reset), .iniciar(iniciar), .VSYNC(VSYNC), .HREF(HREF),
        .PCLK(PCLK), .D(D), .cell_sel(cell_sel), .XCLK(s_XCLK), .PWDN(s_PWDN),
        .ocupado(s_ocupado), .pronto(s_pronto), .erro_frame(s_erro_frame), .pixel(s_pixel),
        .pixel_valido(s_pixel_valido), .cell_r(s_cell_r), .cell_g(s_cell_g), .cell_b(s_cell_b),
        .db_estado(s_db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (pixel_valido === 1'b1) pv_count++;

    // mode 0: all red; mode 1: blue/green/red/white quadrants; mode 2: bytes 0x1F,0x00
    function automatic logic [15:0] pix_val(input int mode, input int line, input int col);
        if (mode == 0) return 16'hF800;
        if (mode == 2) return 16'h1F00;
        if (line < 4) return (col < 4) ? 16'h001F : 16'h07E0;
        return (col < 4) ? 16'hF800 : 16'hFFFF;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        D = b;
        PCLK = 1'b0;
        repeat (3) @(negedge clock);
        PCLK = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic send_line(input int mode, input int line, input int ncols, input bit odd);
        logic [15:0] v;
        @(negedge clock);
        HREF = 1'b1;
        repeat (3) @(negedge clock);
        for (int c = 0; c < ncols; c++) begin
            v = pix_val(mode, line, c);
            send_byte(v[15:8]);
            send_byte(v[7:0]);
        end
        if (odd) send_byte(8'hAA);
        repeat (2) @(negedge clock);
        HREF = 1'b0;
        repeat (6) @(negedge clock);
    endtask

    task automatic pulse_iniciar();
        @(negedge clock);
        iniciar = 1'b1;
        repeat (2) @(negedge clock);
        iniciar = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic frame_body(input int nlines, input int mode, input int short_line, input bit odd);
        @(negedge clock);
        VSYNC = 1'b0;
        repeat (6) @(negedge clock);
        for (int l = 0; l < nlines; l++) send_line(mode, l, (l == short_line) ? 6 : COLS, odd);
        repeat (4) @(negedge clock);
        VSYNC = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic capture(input int nlines, input int mode, input int short_line, input bit odd);
        VSYNC = 1'b1;
        pulse_iniciar();
        repeat (6) @(negedge clock);
        frame_body(nlines, mode, short_line, odd);
    endtask

    task automatic read_cell(input int idx, output int r, output int g, output int b,
                             output int sr, output int sg, output int sb);
        cell_sel = 2'(idx);
        #1;
        r = int'(cell_r);     g = int'(cell_g);     b = int'(cell_b);
        sr = int'(s_cell_r);  sg = int'(s_cell_g);  sb = int'(s_cell_b);
    endtask

    task automatic test_reset();
        logic a;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({db_estado, ocupado, pronto, erro_frame, pixel_valido, pixel, XCLK, PWDN} !== 26'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got estado=%0d ocupado=%b pronto=%b erro=%b pv=%b pixel=%h xclk=%b pwdn=%b, need all 0",
                     db_estado, ocupado, pronto, erro_frame, pixel_valido, pixel, XCLK, PWDN);
        end
        n_cmp++;
        if ({cell_r, cell_g, cell_b} !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_cell: got %0d/%0d/%0d need 0/0/0", cell_r, cell_g, cell_b);
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        a = XCLK;
        @(negedge clock);
        n_cmp++;
        if (XCLK !== ~a) begin
            n_bad++;
            $display("FAIL xclk_toggle: got %b need %b", XCLK, ~a);
        end
    endtask

    task automatic test_red_frame();
        int r, g, b, sr, sg, sb, pv0;
        pv0 = pv_count;
        capture(8, 0, -1, 1'b0);
        n_cmp++;
        if (pronto !== 1'b1 || erro_frame !== 1'b0 || db_estado !== 4'd4) begin
            n_bad++;
            $display("FAIL red_status: got pronto=%b erro=%b estado=%0d need 1 0 4", pronto, erro_frame, db_estado);
        end
        n_cmp++;
        if (pv_count - pv0 !== 64) begin
            n_bad++;
            $display("FAIL red_pixel_count: got %0d need 64", pv_count - pv0);
        end
        n_cmp++;
        if (pixel !== 16'hF800) begin
            n_bad++;
            $display("FAIL red_pixel: got %h need f800", pixel);
        end
        for (int c = 0; c < 4; c++) begin
            read_cell(c, r, g, b, sr, sg, sb);
            n_cmp++;
            if (r !== 31 || g !== 0 || b !== 0) begin
                n_bad++;
                $display("FAIL red_cell%0d: got %0d/%0d/%0d need 31/0/0", c, r, g, b);
            end
        end
    endtask

    task automatic test_mid_frame_quadrants();
        int r, g, b, sr, sg, sb;
        int er[4] = '{0, 0, 31, 31};
        int eg[4] = '{0, 63, 0, 63};
        int eb[4] = '{31, 0, 0, 31};
        @(negedge clock);
        VSYNC = 1'b0;
        repeat (6) @(negedge clock);
        send_line(0, 0, COLS, 1'b0);
        send_line(0, 1, COLS, 1'b0);
        pulse_iniciar();
        n_cmp++;
        if (db_estado !== 4'd1 || pronto !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_wait_high: got estado=%0d pronto=%b need 1 0", db_estado, pronto);
        end
        for (int l = 2; l < 8; l++) send_line(0, l, COLS, 1'b0);
        n_cmp++;
        if (db_estado !== 4'd1) begin
            n_bad++;
            $display("FAIL mid_still_waiting: got estado=%0d need 1", db_estado);
        end
        VSYNC = 1'b1;
        repeat (6) @(negedge clock);
        n_cmp++;
        if (db_estado !== 4'd2) begin
            n_bad++;
            $display("FAIL mid_wait_start: got estado=%0d need 2", db_estado);
        end
        VSYNC = 1'b0;
        repeat (6) @(negedge clock);
        n_cmp++;
        if (db_estado !== 4'd3 || ocupado !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_capture: got estado=%0d ocupado=%b need 3 1", db_estado, ocupado);
        end
        for (int l = 0; l < 8; l++) send_line(1, l, COLS, 1'b0);
        repeat (4) @(negedge clock);
        VSYNC = 1'b1;
        repeat (8) @(negedge clock);
        n_cmp++;
        if (db_estado !== 4'd4 || pronto !== 1'b1 || ocupado !== 1'b0 || erro_frame !== 1'b0) begin
            n_bad++;
            $display("FAIL quad_status: got estado=%0d pronto=%b ocupado=%b erro=%b need 4 1 0 0",
                     db_estado, pronto, ocupado, erro_frame);
        end
        for (int c = 0; c < 4; c++) begin
            read_cell(c, r, g, b, sr, sg, sb);
            n_cmp++;
            if (r !== er[c] || g !== eg[c] || b !== eb[c]) begin
                n_bad++;
                $display("FAIL quad_cell%0d: got %0d/%0d/%0d need %0d/%0d/%0d", c, r, g, b, er[c], eg[c], eb[c]);
            end
        end
    endtask

    task automatic test_frame_errors();
        int r, g, b, sr, sg, sb;
        int er7[4]  = '{31, 31, 23, 23};
        int ers[4]  = '{31, 27, 31, 31};
        capture(7, 0, -1, 1'b0);
        n_cmp++;
        if (pronto !== 1'b1 || erro_frame !== 1'b1) begin
            n_bad++;
            $display("FAIL short_frame_status: got pronto=%b erro=%b need 1 1", pronto, erro_frame);
        end
        for (int c = 0; c < 4; c++) begin
            read_cell(c, r, g, b, sr, sg, sb);
            n_cmp++;
            if (r !== er7[c]) begin
                n_bad++;
                $display("FAIL short_frame_cell%0d_r: got %0d need %0d", c, r, er7[c]);
            end
        end
        capture(8, 0, 0, 1'b0);
        n_cmp++;
        if (pronto !== 1'b1 || erro_frame !== 1'b1) begin
            n_bad++;
            $display("FAIL short_line_status: got pronto=%b erro=%b need 1 1", pronto, erro_frame);
        end
        for (int c = 0; c < 4; c++) begin
            read_cell(c, r, g, b, sr, sg, sb);
            n_cmp++;
            if (r !== ers[c]) begin
                n_bad++;
                $display("FAIL short_line_cell%0d_r: got %0d need %0d", c, r, ers[c]);
            end
        end
        capture(8, 0, -1, 1'b0);
        n_cmp++;
        if (pronto !== 1'b1 || erro_frame !== 1'b0) begin
            n_bad++;
            $display("FAIL recover_status: got pronto=%b erro=%b need 1 0", pronto, erro_frame);
        end
    endtask

    task automatic test_reset_mid_capture();
        int r, g, b, sr, sg, sb, pv0;
        VSYNC = 1'b1;
        pulse_iniciar();
        repeat (6) @(negedge clock);
        VSYNC = 1'b0;
        repeat (6) @(negedge clock);
        send_line(0, 0, COLS, 1'b0);
        send_line(0, 1, COLS, 1'b0);
        HREF = 1'b1;
        repeat (3) @(negedge clock);
        send_byte(8'hF8);
        send_byte(8'h00);
        send_byte(8'hF8);
        n_cmp++;
        if (db_estado !== 4'd3 || ocupado !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_capture: got estado=%0d ocupado=%b need 3 1", db_estado, ocupado);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (db_estado !== 4'd0 || ocupado !== 1'b0 || pronto !== 1'b0 || erro_frame !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got estado=%0d ocupado=%b pronto=%b erro=%b need 0 0 0 0",
                     db_estado, ocupado, pronto, erro_frame);
        end
        read_cell(0, r, g, b, sr, sg, sb);
        n_cmp++;
        if (r !== 0) begin
            n_bad++;
            $display("FAIL async_reset_cell: got r=%0d need 0", r);
        end
        HREF = 1'b0;
        PCLK = 1'b0;
        VSYNC = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        pv0 = pv_count;
        capture(8, 0, -1, 1'b0);
        n_cmp++;
        if (pronto !== 1'b1 || erro_frame !== 1'b0 || pv_count - pv0 !== 64) begin
            n_bad++;
            $display("FAIL after_reset_capture: got pronto=%b erro=%b pixels=%0d need 1 0 64",
                     pronto, erro_frame, pv_count - pv0);
        end
        for (int c = 0; c < 4; c++) begin
            read_cell(c, r, g, b, sr, sg, sb);
            n_cmp++;
            if (r !== 31 || g !== 0 || b !== 0) begin
                n_bad++;
                $display("FAIL after_reset_cell%0d: got %0d/%0d/%0d need 31/0/0", c, r, g, b);
            end
        end
    endtask

    task automatic test_byte_swap_odd();
        int r, g, b, sr, sg, sb, pv0;
        pv0 = pv_count;
        capture(8, 2, -1, 1'b1);
        n_cmp++;
        if (s_pixel !== 16'h001F || pixel !== 16'h1F00) begin
            n_bad++;
            $display("FAIL swap_pixel: got swap=%h normal=%h need 001f 1f00", s_pixel, pixel);
        end
        n_cmp++;
        if (pronto !== 1'b1 || erro_frame !== 1'b0 || s_pronto !== 1'b1 || s_erro_frame !== 1'b0) begin
            n_bad++;
            $display("FAIL odd_byte_status: got pronto=%b erro=%b swap pronto=%b erro=%b need 1 0 1 0",
                     pronto, erro_frame, s_pronto, s_erro_frame);
        end
        n_cmp++;
        if (pv_count - pv0 !== 64) begin
            n_bad++;
            $display("FAIL odd_byte_pixel_count: got %0d need 64", pv_count - pv0);
        end
        for (int c = 0; c < 4; c++) begin
            read_cell(c, r, g, b, sr, sg, sb);
            n_cmp++;
            if (sr !== 0 || sg !== 0 || sb !== 31 || r !== 3 || g !== 56 || b !== 0) begin
                n_bad++;
                $display("FAIL swap_cell%0d: got swap %0d/%0d/%0d normal %0d/%0d/%0d need 0/0/31 and 3/56/0",
                         c, sr, sg, sb, r, g, b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_red_frame();
        test_mid_frame_quadrants();
        test_frame_errors();
        test_reset_mid_capture();
        test_byte_swap_odd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
